// File: rtl/center_pkg.sv
// Shared types and constants for the centre-derivative reconstruction path.
// C_DEFAULT is shared with the derivative stage so both ends divide/multiply by one constant.
package center_pkg;

  typedef enum logic [1:0] {IDLE, DIV, ACC} state_t;

  localparam int NBITS_DEFAULT = 2;
  localparam int OBITS_DEFAULT = 9;
  localparam int DIV_CYCLES    = OBITS_DEFAULT + 1;
  localparam logic [7:0] C_DEFAULT = 8'd180;

endpackage

// File: rtl/center_integrator_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first.
// The dividend register shifts out dividend bits and shifts in quotient bits.
module seq_divider #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [7:0]    divisor,
  output logic          last,
  output logic [DW-1:0] quotient,
  output logic [8:0]    remainder
);

  localparam int CW = $clog2(DW + 1);

  logic [CW-1:0] cnt;
  logic [8:0]    rem_sh;
  logic          fits;

  // Remainder stays below divisor (<= 255), so bit 8 is always clear before the shift.
  assign rem_sh = {remainder[7:0], quotient[DW-1]};
  assign fits   = (rem_sh >= {1'b0, divisor});
  assign last   = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      cnt       <= CW'(DW);
      quotient  <= dividend;
      remainder <= '0;
    end else if (cnt != '0) begin
      remainder <= fits ? (rem_sh - {1'b0, divisor}) : rem_sh;
      quotient  <= {quotient[DW-2:0], fits};
      cnt       <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/center_integrator.sv
// Reconstructs x[n] from scaled first differences: divide by C, then accumulate mod 2^(Nbits+1).
// One sample in flight at a time; out_valid strobes once per accepted sample.
module center_integrator
  import center_pkg::*;
#(
  parameter int         Nbits = NBITS_DEFAULT,
  parameter int         Obits = OBITS_DEFAULT,
  parameter logic [7:0] C     = C_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [Obits:0] in_der,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           init_load,
  input  logic [Nbits:0] init_val,
  output logic [Nbits:0] out_sig,
  output logic           out_valid,
  output logic           rem_err
);

  state_t         state, state_nxt;
  logic           div_start;
  logic           div_last;
  logic [Obits:0] div_q;
  logic [8:0]     div_rem;
  logic           unused_q_hi;

  seq_divider #(.DW(Obits + 1)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (in_der),
    .divisor   (C),
    .last      (div_last),
    .quotient  (div_q),
    .remainder (div_rem)
  );

  // Quotient bits above Nbits wrap away, mirroring the forward stage's modular subtract.
  assign unused_q_hi = ^div_q[Obits:Nbits+1];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          div_start = 1'b1;
          state_nxt = DIV;
        end
      end
      DIV:     if (div_last) state_nxt = ACC;
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_sig   <= '0;
      out_valid <= 1'b0;
      rem_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state == ACC);
      if (state == ACC) rem_err <= (div_rem != '0);
      // A preset on the ACC edge overrides that sample's delta.
      if (init_load)          out_sig <= init_val;
      else if (state == ACC)  out_sig <= out_sig + div_q[Nbits:0];
    end
  end

endmodule

// File: tb/tb_center_integrator.sv
// Directed bench for center_integrator (Nbits=2, Obits=9, C=180).
module tb_center_integrator;

  localparam int         NB = 2;
  localparam int         OB = 9;
  localparam logic [7:0] CC = 8'd180;

  logic          clk = 1'b0;
  logic          rst;
  logic [OB:0]   in_der;
  logic          in_valid;
  logic          in_ready;
  logic          init_load;
  logic [NB:0]   init_val;
  logic [NB:0]   out_sig;
  logic          out_valid;
  logic          rem_err;

  int total = 0, passed = 0;
  int cyc = 0, acc_cnt = 0, ov_cnt = 0, acc_cyc = 0, prev_acc_cyc = 0, ov_cyc = 0, rdy_viol = 0;
  bit busy = 1'b0;

  always #5 clk = ~clk;

  center_integrator #(.Nbits(NB), .Obits(OB), .C(CC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_der    (in_der),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .init_load (init_load),
    .init_val  (init_val),
    .out_sig   (out_sig),
    .out_valid (out_valid),
    .rem_err   (rem_err)
  );

  // Edge-indexed monitor: acceptances, strobes, and in_ready while a sample is in flight.
  always @(posedge clk) begin
    if (rst) busy = 1'b0;
    else begin
      if (out_valid) begin busy = 1'b0; ov_cnt++; ov_cyc = cyc; end
      if (busy && in_ready) rdy_viol++;
      if (in_valid && in_ready) begin
        busy = 1'b1; acc_cnt++; prev_acc_cyc = acc_cyc; acc_cyc = cyc;
      end
    end
    cyc++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 50) begin @(negedge clk); n++; end
    if (acc_cnt < target) check("accept_timeout", acc_cnt, target);
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic send(input logic [OB:0] v);
    int t;
    t = acc_cnt + 1;
    in_der = v;
    in_valid = 1'b1;
    wait_acc(t);
    in_valid = 1'b0;
  endtask

  // Full transaction: result, remainder flag, 12-edge latency, single-cycle strobe.
  task automatic sample(input string tag, input logic [OB:0] v, input int exp_sig, input int exp_rem);
    send(v);
    wait_ov();
    check({tag, "_sig"}, int'(out_sig), exp_sig);
    check({tag, "_rem"}, int'(rem_err), exp_rem);
    check({tag, "_rdy_with_ov"}, int'(in_ready), 1);
    @(negedge clk);
    check({tag, "_latency"}, ov_cyc - acc_cyc, 12);
    check({tag, "_ov_one_cycle"}, int'(out_valid), 0);
  endtask

  initial begin
    int o, a;
    rst = 1'b1; in_der = '0; in_valid = 1'b0; init_load = 1'b0; init_val = '0;
    repeat (2) @(negedge clk);
    check("rst_out_sig", int'(out_sig), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_rem_err", int'(rem_err), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);

    // 360/180 = 2
    sample("s360", 10'd360, 2, 0);

    // preset 0, then 540 (q=3) and 900 (q=5) back-to-back with in_valid held
    init_val = 3'd0; init_load = 1'b1;
    @(negedge clk);
    init_load = 1'b0;
    check("preset0", int'(out_sig), 0);
    a = acc_cnt;
    in_der = 10'd540; in_valid = 1'b1;
    wait_acc(a + 1);
    in_der = 10'd900;
    wait_ov();
    check("b2b_first", int'(out_sig), 3);
    wait_acc(a + 2);
    in_valid = 1'b0;
    check("b2b_spacing", acc_cyc - prev_acc_cyc, 12);
    wait_ov();
    check("b2b_second", int'(out_sig), 0);
    @(negedge clk);

    // zero input: q=0, accumulator unchanged, still strobes
    sample("s0", 10'd0, 0, 0);
    // 181 -> q=1 rem 1; 1023 -> q=5 rem 123; 180 -> q=1 rem 0
    sample("s181", 10'd181, 1, 1);
    sample("s1023", 10'd1023, 6, 1);
    sample("s180", 10'd180, 7, 0);

    // preset 6, then +2 wraps to 0
    init_val = 3'd6; init_load = 1'b1;
    @(negedge clk);
    init_load = 1'b0;
    check("preset6", int'(out_sig), 6);
    sample("wrap", 10'd360, 0, 0);

    // preset landing on the ACC edge wins over the sample's delta
    send(10'd180);
    repeat (10) @(negedge clk);
    init_val = 3'd3; init_load = 1'b1;
    @(negedge clk);
    init_load = 1'b0;
    check("acc_init_ov", int'(out_valid), 1);
    check("acc_init_sig", int'(out_sig), 3);
    o = ov_cnt;
    repeat (3) @(negedge clk);
    check("acc_init_one_pulse", ov_cnt - o, 1);

    // reset in the middle of a division discards it
    send(10'd360);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_sig", int'(out_sig), 0);
    check("midrst_ov", int'(out_valid), 0);
    check("midrst_rdy", int'(in_ready), 1);
    o = ov_cnt;
    repeat (15) @(negedge clk);
    check("midrst_no_stray", ov_cnt - o, 0);
    sample("s720", 10'd720, 4, 0);

    // input changes and in_valid pulses while busy are ignored
    o = ov_cnt; a = acc_cnt;
    send(10'd360);
    in_der = 10'd1000;
    @(negedge clk); @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov();
    check("busy_ignore_sig", int'(out_sig), 6);
    repeat (3) @(negedge clk);
    check("busy_accepts", acc_cnt - a, 1);
    check("busy_strobes", ov_cnt - o, 1);
    check("ready_low_while_busy", rdy_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
